// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the sequential scalar multiplier.
//   state_e   - FSM states IDLE / BUSY / DONE.
//   cnt_width - width of a step counter that must hold values 0..entry_size.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter counts down from entry_size to 0 and never wraps.
  function automatic int unsigned cnt_width(input int unsigned entry_size);
    return $clog2(entry_size + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// mult_step: one combinational radix-2 shift-add step.
// Ports:
//   i_acc    - running partial product
//   i_mcand  - multiplicand, already shifted for the current step
//   i_mplier - remaining multiplier bits (LSB is the current bit)
//   o_acc    - partial product after adding i_mcand when i_mplier[0] is set
//   o_mcand  - multiplicand shifted left by one
//   o_mplier - multiplier shifted right by one
module mult_step #(
  parameter int unsigned ENTRY_SIZE = 5
) (
  input  logic [2*ENTRY_SIZE-1:0] i_acc,
  input  logic [2*ENTRY_SIZE-1:0] i_mcand,
  input  logic [ENTRY_SIZE-1:0]   i_mplier,
  output logic [2*ENTRY_SIZE-1:0] o_acc,
  output logic [2*ENTRY_SIZE-1:0] o_mcand,
  output logic [ENTRY_SIZE-1:0]   o_mplier
);

  always_comb begin
    o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
  end

endmodule

// File: rtl/seq_scalar_multiplier.sv
// seq_scalar_multiplier: sequential shift-add multiplier with valid/ready handshakes.
// Computes a*b over ENTRY_SIZE steps at 2*ENTRY_SIZE bits, then fits the product into
// RESENTRY_SIZE bits and flags overflow.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready high only in IDLE, low during reset)
//   a, b                 - multiplicand / multiplier (ENTRY_SIZE bits)
//   out_valid/out_ready  - result handshake (out_valid high in DONE)
//   result, overflow     - fitted product and overflow flag, held stable in DONE
// Configuration: define SIGNED_MULT_EN for two's complement operands (adds one BUSY cycle
// for the sign fix-up); undefined gives unsigned-only operation.
module seq_scalar_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned ENTRY_SIZE    = 5,
  parameter int unsigned RESENTRY_SIZE = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ENTRY_SIZE-1:0]    a,
  input  logic [ENTRY_SIZE-1:0]    b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RESENTRY_SIZE-1:0] result,
  output logic                     overflow
);

  localparam int unsigned ProdW = 2 * ENTRY_SIZE;
  localparam int unsigned CntW  = cnt_width(ENTRY_SIZE);
  localparam int unsigned ExtW  = (RESENTRY_SIZE > ProdW) ? RESENTRY_SIZE : ProdW;

  state_e                   r_state, w_state_d;
  logic [ProdW-1:0]         r_acc, w_acc_d;
  logic [ProdW-1:0]         r_mcand, w_mcand_d;
  logic [ENTRY_SIZE-1:0]    r_mplier, w_mplier_d;
  logic [CntW-1:0]          r_cnt, w_cnt_d;
  logic [RESENTRY_SIZE-1:0] r_result, w_result_d;
  logic                     r_ovf, w_ovf_d;

  logic [ProdW-1:0]         w_step_acc, w_step_mcand;
  logic [ENTRY_SIZE-1:0]    w_step_mplier;
  logic [ExtW-1:0]          w_ext, w_top;
  logic                     w_fmt_ovf;

`ifdef SIGNED_MULT_EN
  logic                     r_neg, w_neg_d;
  logic                     r_fixed, w_fixed_d;
  logic [ENTRY_SIZE-1:0]    w_mag_a, w_mag_b;

  // -(-2^(N-1)) wraps to 2^(N-1), which is still the right unsigned magnitude.
  assign w_mag_a = a[ENTRY_SIZE-1] ? -a : a;
  assign w_mag_b = b[ENTRY_SIZE-1] ? -b : b;
`endif

  mult_step #(
    .ENTRY_SIZE(ENTRY_SIZE)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_mplier(r_mplier),
    .o_acc   (w_step_acc),
    .o_mcand (w_step_mcand),
    .o_mplier(w_step_mplier)
  );

  // Fit the full product into RESENTRY_SIZE bits; w_top holds the bits that get discarded.
  always_comb begin
`ifdef SIGNED_MULT_EN
    w_ext     = ExtW'($signed(r_acc));
    w_top     = $signed(w_ext) >>> (RESENTRY_SIZE - 1);
    // In range iff the discarded bits plus the new sign bit are all copies of the sign.
    w_fmt_ovf = !((w_top == '0) || (w_top == '1));
`else
    w_ext     = ExtW'(r_acc);
    w_top     = w_ext >> RESENTRY_SIZE;
    w_fmt_ovf = |w_top;
`endif
  end

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_cnt_d    = r_cnt;
    w_result_d = r_result;
    w_ovf_d    = r_ovf;
`ifdef SIGNED_MULT_EN
    w_neg_d    = r_neg;
    w_fixed_d  = r_fixed;
`endif
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_acc_d    = '0;
          w_cnt_d    = CntW'(ENTRY_SIZE);
          w_state_d  = BUSY;
`ifdef SIGNED_MULT_EN
          w_mcand_d  = ProdW'(w_mag_a);
          w_mplier_d = w_mag_b;
          w_neg_d    = a[ENTRY_SIZE-1] ^ b[ENTRY_SIZE-1];
          w_fixed_d  = 1'b0;
`else
          w_mcand_d  = ProdW'(a);
          w_mplier_d = b;
`endif
        end
      end
      BUSY: begin
        if (r_cnt != '0) begin
          w_acc_d    = w_step_acc;
          w_mcand_d  = w_step_mcand;
          w_mplier_d = w_step_mplier;
          w_cnt_d    = r_cnt - CntW'(1);
        end
`ifdef SIGNED_MULT_EN
        else if (!r_fixed) begin
          w_fixed_d = 1'b1;
          if (r_neg) begin
            w_acc_d = -r_acc;
          end
        end
`endif
        else begin
          w_result_d = w_ext[RESENTRY_SIZE-1:0];
          w_ovf_d    = w_fmt_ovf;
          w_state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
`ifdef SIGNED_MULT_EN
      r_neg    <= 1'b0;
      r_fixed  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_cnt    <= w_cnt_d;
      r_result <= w_result_d;
      r_ovf    <= w_ovf_d;
`ifdef SIGNED_MULT_EN
      r_neg    <= w_neg_d;
      r_fixed  <= w_fixed_d;
`endif
    end
  end

  // Both handshake outputs come from state only; rst_n gates in_ready while reset is held.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign overflow  = r_ovf;

endmodule

// File: doc/seq_scalar_multiplier.md
SEQ_SCALAR_MULTIPLIER -- requirements
Module: seq_scalar_multiplier

Interface
REQ-001 Parameter ENTRY_SIZE, default 5: operand width of a and b.
REQ-002 Parameter RESENTRY_SIZE, default 9: result width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operands a and b present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  ENTRY_SIZE  multiplicand.
REQ-008 b  input  ENTRY_SIZE  multiplier.
REQ-009 out_valid  output  1  result and overflow valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  RESENTRY_SIZE  product a*b, fitted to RESENTRY_SIZE.
REQ-012 overflow  output  1  product not representable in RESENTRY_SIZE bits.

Function
REQ-013 FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 IDLE: in_ready=1; in_valid=1 at an edge SHALL capture a and b, clear the accumulator, load the step counter with ENTRY_SIZE, and go to BUSY.
REQ-015 BUSY: one radix-2 shift-add step per cycle (add shifted multiplicand when multiplier LSB=1; shift multiplier right); in_ready=0; in_valid ignored.
REQ-016 BUSY SHALL go to DONE on the edge that completes step ENTRY_SIZE; out_valid SHALL first be high ENTRY_SIZE+1 edges after the accepting edge.
REQ-017 Full product SHALL be computed at 2*ENTRY_SIZE bits; result = low RESENTRY_SIZE bits, zero-extended when RESENTRY_SIZE > 2*ENTRY_SIZE.
REQ-018 overflow SHALL be 1 iff any discarded product bit is nonzero (unsigned mode).
REQ-019 DONE: out_valid=1; result and overflow SHALL hold stable while out_ready=0.
REQ-020 DONE with out_ready=1 at an edge SHALL return to IDLE; no combinational path from in_valid to out_valid or from out_ready to in_ready.
REQ-021 Operand 0 on either input SHALL still take the full ENTRY_SIZE steps and yield result 0, overflow 0.
REQ-022 Step counter SHALL be clog2(ENTRY_SIZE+1) bits and SHALL never wrap.

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE, in_ready=1 (after release), out_valid=0, result=0, overflow=0, counter=0, from any state including mid-BUSY; partial product discarded.
REQ-024 in_ready SHALL be 0 during any cycle rst_n=0.

Configuration
REQ-025 Macro SIGNED_MULT_EN defined: a and b are two's complement; magnitudes are multiplied and the result negated when signs differ; result sign-extended when wider; overflow=1 iff the full signed product lies outside the RESENTRY_SIZE signed range; one extra BUSY cycle for the sign fix-up (latency ENTRY_SIZE+2).
REQ-026 Macro undefined: unsigned operation only, latency per REQ-016, no sign logic present.

Structure
REQ-027 Package mult_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the counter-width function.
REQ-028 One sub-module, mult_step, SHALL implement the combinational single shift-add step; FSM, registers and handshake stay in the top.

Verification (ENTRY_SIZE=5, RESENTRY_SIZE=9)
REQ-029 a=7, b=9 -> out_valid 6 edges after accept; result=63, overflow=0.
REQ-030 a=31, b=31 -> result=449 (961 mod 512), overflow=1.
REQ-031 Result held with out_ready=0 for 10 cycles -> result, out_valid stable; in_ready=0 throughout; then out_ready=1 -> IDLE next edge, back-to-back operand accepted next cycle.
REQ-032 rst_n=0 at step 3 of a=21, b=13 -> out_valid=0, result=0; new a=2, b=3 after release -> result=6.
REQ-033 SIGNED_MULT_EN: a=-3 (5'b11101), b=5 -> result=9'h1F1 (-15), overflow=0, latency 7 edges; a=-16, b=-16 -> 256, overflow=1.
REQ-034 a=0, b=31 -> result=0, overflow=0, same latency as REQ-029.
